button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Input-side counterpart to the LED driver path: samples WIDTH raw push-buttons/switches from board pins.
- Synchronises the inputs into clk, debounces them with a sampled stable-count filter and presents clean levels.
- Emits single-cycle press and release pulses that downstream logic (LED counter control, mode select) consumes directly.
- Contains its own sample-tick divider so it needs only the system clock.

Parameters:
- CLK_FREQ, 200_000_000, system clock frequency in Hz.
- SAMPLE_FREQ, 1_000, debounce sample rate in Hz; tick period DIV = CLK_FREQ/SAMPLE_FREQ cycles.
- STABLE_SAMPLES, 8, consecutive mismatching ticks required before a level change is accepted.
- WIDTH, 8, number of input channels.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset; 0 = in reset.
- btn_raw  input  WIDTH  raw asynchronous pin levels, active-high.
- btn_level  output  WIDTH  debounced level per channel.
- btn_press  output  WIDTH  one-cycle pulse on accepted 0->1 change.
- btn_release  output  WIDTH  one-cycle pulse on accepted 1->0 change.
- any_change  output  1  OR of btn_press|btn_release, same cycle.

Behaviour:
- Reset (rst=0, async assert, sync deassert within the block's own flops):
  - sync stages, btn_level, btn_press, btn_release, any_change, divider and all channel counters = 0.
- Synchroniser: 2-flop chain per channel; sync[i] lags btn_raw[i] by 2 clk edges. No logic between stages.
- Sample tick:
  - Divider counts 0..DIV-1.
  - tick=1 for exactly one cycle when the counter == DIV-1, after which the counter wraps to 0.
  - First tick occurs DIV cycles after reset release.
- Per channel i, cnt width $clog2(STABLE_SAMPLES)+1:
  - sync[i]==btn_level[i]: cnt<=0 every cycle, tick or not. Any return to the current level restarts the filter.
  - sync[i]!=btn_level[i] and tick:
    - If cnt==STABLE_SAMPLES-1: btn_level[i]<=sync[i], cnt<=0, and the matching pulse (press if new level 1, else release) is asserted in the same cycle btn_level updates.
    - Otherwise: cnt<=cnt+1.
  - sync[i]!=btn_level[i] and no tick: hold cnt.
- Pulses: registered, high exactly one cycle, never both press and release on one channel in the same cycle.
- Channels are fully independent; simultaneous acceptance on several channels is legal and raises several bits in one cycle.
- Latency: stable input edge to level change = 2 cycles + between (STABLE_SAMPLES-1)*DIV+1 and STABLE_SAMPLES*DIV cycles, depending on tick phase.
- Filtering: a glitch or bounce holding for fewer than STABLE_SAMPLES consecutive ticks produces no output change.
- Reset mid-count: every channel counter is cleared, levels return to 0, and no pulse is emitted on release of reset. An input held at 1 through reset is then re-accepted as a press after the normal latency.
- Elaboration checks: STABLE_SAMPLES>=1 and CLK_FREQ>=SAMPLE_FREQ, else $error.
- STABLE_SAMPLES==1: a change is accepted on the first tick that sees a mismatch.

Decomposition:
- Shared package board_io_pkg: function clog2-based width helpers and constant DEFAULT_SAMPLE_FREQ.
- Sub-module debounce_chan (one channel):
  - Contains the 2-flop sync, stable counter, level and press/release registers.
  - Takes tick as an input.
- The top holds the sample-tick divider, a generate loop of WIDTH debounce_chan instances, and the any_change OR.

Test Plan (sim params CLK_FREQ=1000, SAMPLE_FREQ=100 so DIV=10, STABLE_SAMPLES=4, WIDTH=8):
- Reset: hold rst=0 with btn_raw=8'hFF -> all outputs 0. Release rst -> btn_level=8'hFF reached 33..42 cycles later, with press=8'hFF for exactly one cycle and no release pulse.
- Clean press: btn_raw[0] 0->1 held 100 cycles -> btn_level[0] rises 33..42 cycles after the edge, in the same cycle as a single press[0] and any_change pulse. Dropping to 0 gives the same latency with one release[0].
- Bounce: btn_raw[3] toggling every 5 cycles for 200 cycles, then settling at 0 -> btn_level[3] stays 0 and no pulses at any point.
- Near-miss: btn_raw[5]=1 for exactly 3 ticks' worth (30 cycles, aligned) then 0 -> no change. A 4th tick held -> accepted.
- Simultaneous: btn_raw 8'h00->8'hA5 in one cycle -> press=8'hA5 in one cycle and btn_level=8'hA5.
- Reset mid-count: btn_raw[1]=1, assert rst after 2 ticks, release -> no pulse at release. Press accepted 33..42 cycles after reset release.

Source files
------------

// File: rtl/board_io_pkg.sv
// rtl/board_io_pkg.sv - shared constants and width helpers for board I/O blocks
package board_io_pkg;

  localparam int DEFAULT_SAMPLE_FREQ = 1_000;

  // Stable counter must hold 0..STABLE_SAMPLES-1 with one spare bit of headroom.
  function automatic int cnt_width(input int stable_samples);
    return $clog2(stable_samples) + 1;
  endfunction

  // Divider width; a divide-by-1 still needs a one-bit register.
  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one channel: 2-flop sync, stable-count filter, level and edge pulses
module debounce_chan
  import board_io_pkg::*;
#(
  parameter int STABLE_SAMPLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = cnt_width(STABLE_SAMPLES);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;

  // Bring the asynchronous pin into clk; plain flop-to-flop chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Filter: any cycle agreeing with the current level restarts the count;
  // a level change needs STABLE_SAMPLES mismatching ticks in a row.
  always_comb begin
    level_d   = level_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_W'(STABLE_SAMPLES - 1)) begin
        level_d   = sync2_q;
        cnt_d     = '0;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Level, counter and pulses update together so a pulse coincides with its level change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - multi-channel button debouncer with internal sample-tick divider
module button_debouncer
  import board_io_pkg::*;
#(
  parameter int CLK_FREQ       = 200_000_000,
  parameter int SAMPLE_FREQ    = DEFAULT_SAMPLE_FREQ,
  parameter int STABLE_SAMPLES = 8,
  parameter int WIDTH          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic             any_change
);

  localparam int DIV   = CLK_FREQ / SAMPLE_FREQ;
  localparam int DIV_W = div_width(DIV);

  if (STABLE_SAMPLES < 1) begin : g_bad_stable
    $error("button_debouncer: STABLE_SAMPLES must be >= 1");
  end
  if (CLK_FREQ < SAMPLE_FREQ) begin : g_bad_freq
    $error("button_debouncer: CLK_FREQ must be >= SAMPLE_FREQ");
  end

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick;

  // Tick is high for the single cycle the divider sits at its terminal count.
  assign tick = (div_q == DIV_W'(DIV - 1));

  // Next divider value: wrap to 0 after the terminal count.
  always_comb begin
    div_d = div_q + 1'b1;
    if (tick) begin
      div_d = '0;
    end
  end

  // Sample-tick divider register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_chan #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

  assign any_change = |(btn_press | btn_release);

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer
module tb_button_debouncer;

  localparam int CLK_FREQ    = 1000;
  localparam int SAMPLE_FREQ = 100;
  localparam int DIV         = CLK_FREQ / SAMPLE_FREQ;
  localparam int STABLE      = 4;
  localparam int W           = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] btn_raw = '0;
  logic [W-1:0] btn_level;
  logic [W-1:0] btn_press;
  logic [W-1:0] btn_release;
  logic         any_change;

  always #5 clk = ~clk;

  button_debouncer #(
    .CLK_FREQ      (CLK_FREQ),
    .SAMPLE_FREQ   (SAMPLE_FREQ),
    .STABLE_SAMPLES(STABLE),
    .WIDTH         (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_change (any_change)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d t=%0t", name, v, lo, hi, $time);
    end
  endtask

  // Reference: the pin as seen two edges ago is compared to the accepted level;
  // a level is accepted once STABLE sample ticks have all seen it differ.
  logic [W-1:0] m_lvl   = '0;
  logic [W-1:0] m_press = '0;
  logic [W-1:0] m_rel   = '0;
  logic [W-1:0] m_seen  = '0;
  logic [W-1:0] hist1   = '0;
  logic [W-1:0] hist2   = '0;
  int           edges   = 0;
  int           ticks_differing[W];
  bit           sample_now;

  initial begin
    for (int i = 0; i < W; i++) ticks_differing[i] = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_lvl = '0; m_press = '0; m_rel = '0;
        hist1 = '0; hist2 = '0; edges = 0;
        for (int i = 0; i < W; i++) ticks_differing[i] = 0;
      end else begin
        m_seen     = hist2;
        edges      = edges + 1;
        sample_now = (edges % DIV) == 0;
        hist2      = hist1;
        hist1      = btn_raw;
        m_press    = '0;
        m_rel      = '0;
        for (int i = 0; i < W; i++) begin
          if (m_seen[i] == m_lvl[i]) begin
            ticks_differing[i] = 0;
          end else if (sample_now) begin
            ticks_differing[i] = ticks_differing[i] + 1;
            if (ticks_differing[i] == STABLE) begin
              m_lvl[i] = m_seen[i];
              ticks_differing[i] = 0;
              if (m_seen[i]) m_press[i] = 1'b1;
              else           m_rel[i]   = 1'b1;
            end
          end
        end
      end
    end
  end

  int           press_cnt[W];
  int           rel_cnt[W];
  int           press_cycles = 0;
  logic [W-1:0] last_press = '0;

  // Per-cycle comparison against the reference, plus pulse bookkeeping.
  initial begin
    for (int i = 0; i < W; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      chk("level", btn_level, m_lvl);
      chk("press", btn_press, m_press);
      chk("release", btn_release, m_rel);
      chk("any_change", any_change, |(m_press | m_rel));
      chk("press_and_release", btn_press & btn_release, 0);
      for (int i = 0; i < W; i++) begin
        if (btn_press[i])   press_cnt[i]++;
        if (btn_release[i]) rel_cnt[i]++;
      end
      if (btn_press != '0) begin
        press_cycles++;
        last_press = btn_press;
      end
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < W; i++) begin press_cnt[i] = 0; rel_cnt[i] = 0; end
    press_cycles = 0;
    last_press   = '0;
  endtask

  function automatic int rel_total();
    int s = 0;
    for (int i = 0; i < W; i++) s += rel_cnt[i];
    return s;
  endfunction

  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    #1;
    btn_raw = v;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_lvl(input logic [W-1:0] mask, input logic [W-1:0] val,
                          input int budget, output int cyc);
    cyc = 0;
    while (((btn_level & mask) !== val) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if ((btn_level & mask) !== val) begin
      checks++;
      errors++;
      $display("FAIL wait_level_timeout actual=%0h expected=%0h t=%0t", btn_level & mask, val, $time);
    end
  endtask

  int cyc;

  initial begin
    // Reset with all pins high.
    rst     = 1'b0;
    btn_raw = 8'hFF;
    settle(5);
    chk("reset_level", btn_level, 8'h00);
    chk("reset_press", btn_press, 8'h00);
    @(negedge clk); #1; rst = 1'b1;
    clear_counts();
    wait_lvl(8'hFF, 8'hFF, 60, cyc);
    chk("reset_release_latency", cyc, 40);
    settle(2);
    chk("reset_press_cycles", press_cycles, 1);
    chk("reset_press_vec", last_press, 8'hFF);
    chk("reset_no_release", rel_total(), 0);
    drive(8'h00);
    wait_lvl(8'hFF, 8'h00, 60, cyc);
    settle(2);

    // Clean press and release on channel 0.
    clear_counts();
    drive(8'h01);
    wait_lvl(8'h01, 8'h01, 60, cyc);
    chk_range("press0_latency", cyc, 33, 42);
    settle(100 - cyc);
    chk("press0_count", press_cnt[0], 1);
    chk("press0_vec", last_press, 8'h01);
    drive(8'h00);
    wait_lvl(8'h01, 8'h00, 60, cyc);
    chk_range("release0_latency", cyc, 33, 42);
    settle(5);
    chk("release0_count", rel_cnt[0], 1);
    chk("press0_count_after", press_cnt[0], 1);

    // Bounce on channel 3: toggling every 5 cycles never survives 4 ticks.
    clear_counts();
    for (int k = 0; k < 40; k++) begin
      drive((k % 2) == 0 ? 8'h08 : 8'h00);
      settle(4);
    end
    settle(60);
    chk("bounce3_level", btn_level[3], 1'b0);
    chk("bounce3_press", press_cnt[3], 0);
    chk("bounce3_release", rel_cnt[3], 0);

    // Near-miss on channel 5: 30 cycles span exactly 3 ticks, 50 cycles enough.
    clear_counts();
    drive(8'h20);
    settle(29);
    drive(8'h00);
    settle(40);
    chk("nearmiss5_level", btn_level[5], 1'b0);
    chk("nearmiss5_press", press_cnt[5], 0);
    drive(8'h20);
    wait_lvl(8'h20, 8'h20, 60, cyc);
    chk_range("accept5_latency", cyc, 33, 42);
    settle(2);
    chk("accept5_press", press_cnt[5], 1);
    drive(8'h00);
    wait_lvl(8'h20, 8'h00, 60, cyc);
    settle(2);

    // Simultaneous acceptance on several channels.
    clear_counts();
    drive(8'hA5);
    wait_lvl(8'hFF, 8'hA5, 60, cyc);
    settle(2);
    chk("simul_press_cycles", press_cycles, 1);
    chk("simul_press_vec", last_press, 8'hA5);
    chk("simul_level", btn_level, 8'hA5);
    drive(8'h00);
    wait_lvl(8'hFF, 8'h00, 60, cyc);
    settle(2);

    // Reset in the middle of a count on channel 1.
    clear_counts();
    drive(8'h02);
    settle(24);
    @(negedge clk); #1; rst = 1'b0;
    settle(3);
    chk("midrst_level", btn_level, 8'h00);
    @(negedge clk); #1; rst = 1'b1;
    wait_lvl(8'h02, 8'h02, 60, cyc);
    chk("midrst_latency", cyc, 40);
    settle(2);
    chk("midrst_press", press_cnt[1], 1);
    chk("midrst_no_release", rel_total(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
